// File: rtl/word_memory_bank_pkg.sv
// Shared types and defaults for the word memory bank and its clear controller.
package memory_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

endpackage

// File: rtl/word_memory_bank_if.sv
// Request/response bundle between a word memory bank and its user.
interface word_memory_bank_if #(
  parameter int unsigned WIDTH  = memory_pkg::DEFAULT_WIDTH,
  parameter int unsigned DEPTH  = memory_pkg::DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
);

  logic              store;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  data;
  logic [ADDR_W-1:0] rd_addr;
  logic              clear;
  logic [WIDTH-1:0]  memory;
  logic [WIDTH-1:0]  n_mem;
  logic              rd_valid;
  logic              busy;
  logic              store_ack;

  modport master (
    output store, wr_addr, data, rd_addr, clear,
    input  memory, n_mem, rd_valid, busy, store_ack
  );

  modport slave (
    input  store, wr_addr, data, rd_addr, clear,
    output memory, n_mem, rd_valid, busy, store_ack
  );

endinterface

// File: rtl/word_memory_bank_clear_ctrl.sv
// Sequential-clear controller: walks every word index once per clear request.
module mem_clear_ctrl
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          // clear requests here are ignored; the walk always completes
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign clr_en   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/word_memory_bank.sv
// Word-addressed storage with one-cycle registered read, per-word valid bits
// and a sequential clear that locks out stores while it runs.
module word_memory_bank
  import memory_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  word_memory_bank_if.slave bus
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              accept;

  mem_clear_ctrl #(.DEPTH(DEPTH)) u_clear_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (bus.clear),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // A clear request in the same cycle takes priority over a store
  assign accept   = bus.store && !busy && !bus.clear;
  assign bus.busy = busy;

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (accept) begin
      mem[bus.wr_addr] <= bus.data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid         <= '0;
      bus.memory    <= '0;
      bus.rd_valid  <= 1'b0;
      bus.store_ack <= 1'b0;
    end else begin
      if (clr_en) begin
        valid[clr_addr] <= 1'b0;
      end else if (accept) begin
        valid[bus.wr_addr] <= 1'b1;
      end
      // Reads see pre-edge array and valid state: read-before-write
      bus.memory    <= valid[bus.rd_addr] ? mem[bus.rd_addr] : '0;
      bus.rd_valid  <= valid[bus.rd_addr];
      bus.store_ack <= accept;
    end
  end

  assign bus.n_mem = ~bus.memory;

endmodule

// File: tb/tb_word_memory_bank.sv
// Directed vector bench for word_memory_bank with hand-computed expectations.
module tb_word_memory_bank;

  logic clk;
  logic reset_n;

  word_memory_bank_if #(.WIDTH(8), .DEPTH(16)) bus ();

  word_memory_bank #(.WIDTH(8), .DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic       store;
    logic [3:0] wr_addr;
    logic [7:0] data;
    logic [3:0] rd_addr;
    logic [7:0] exp_mem;
    logic       exp_rdv;
    logic       exp_ack;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_read(input string name, input logic [7:0] exp_mem, input logic exp_rdv);
    logic [7:0] exp_n;
    exp_n = ~exp_mem;
    chk({name, ".memory"}, 32'(bus.memory), 32'(exp_mem));
    chk({name, ".n_mem"}, 32'(bus.n_mem), 32'(exp_n));
    chk({name, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp_rdv));
  endtask

  // Counts busy samples from the current one on, holding store asserted
  task automatic run_clear(output int cyc, output int acks, input logic [3:0] probe_addr,
                           input logic [7:0] probe_val);
    cyc  = 0;
    acks = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      if (bus.store_ack) acks++;
      if (cyc == 8) chk_read("clear_mid_probe", probe_val, 1'b1);
      tick();
    end
    if (bus.store_ack) acks++;
  endtask

  initial begin
    int cyc;
    int acks;

    vecs[0] = '{1'b1, 4'd3,  8'hA5, 4'd3,  8'h00, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 4'd0,  8'h00, 4'd3,  8'hA5, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'd7,  8'h11, 4'd0,  8'h00, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 4'd7,  8'h3C, 4'd7,  8'h11, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 4'd0,  8'h00, 4'd7,  8'h3C, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 4'd15, 8'hFF, 4'd15, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 4'd0,  8'h00, 4'd15, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 4'd0,  8'h00, 4'd3,  8'hA5, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 4'd0,  8'h00, 4'd0,  8'h00, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 4'd0,  8'h00, 4'd1,  8'h00, 1'b0, 1'b0};

    reset_n     = 1'b0;
    bus.store   = 1'b0;
    bus.wr_addr = '0;
    bus.data    = '0;
    bus.rd_addr = '0;
    bus.clear   = 1'b0;
    #12;
    chk_read("reset", 8'h00, 1'b0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.store_ack", 32'(bus.store_ack), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = 4'(i);
      tick();
      chk_read($sformatf("blank_rd%0d", i), 8'h00, 1'b0);
    end

    for (int i = 0; i < 10; i++) begin
      bus.store   = vecs[i].store;
      bus.wr_addr = vecs[i].wr_addr;
      bus.data    = vecs[i].data;
      bus.rd_addr = vecs[i].rd_addr;
      tick();
      chk_read($sformatf("vec%0d", i), vecs[i].exp_mem, vecs[i].exp_rdv);
      chk($sformatf("vec%0d.store_ack", i), 32'(bus.store_ack), 32'(vecs[i].exp_ack));
    end

    // Fill every word, then clear with store held high throughout
    for (int i = 0; i < 16; i++) begin
      bus.store   = 1'b1;
      bus.wr_addr = 4'(i);
      bus.data    = 8'h80 | 8'(i);
      tick();
    end
    bus.wr_addr = 4'd5;
    bus.data    = 8'hEE;
    bus.rd_addr = 4'd15;
    bus.clear   = 1'b1;
    tick();
    bus.clear   = 1'b0;
    run_clear(cyc, acks, 4'd15, 8'h8F);
    bus.store = 1'b0;
    chk("clear_full.busy_cycles", 32'(cyc), 32'd16);
    chk("clear_full.acks", 32'(acks), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr = 4'(i);
      tick();
      chk_read($sformatf("post_clear_rd%0d", i), 8'h00, 1'b0);
    end

    // Clear and store in the same idle cycle
    bus.store   = 1'b1;
    bus.wr_addr = 4'd2;
    bus.data    = 8'h42;
    bus.clear   = 1'b1;
    tick();
    bus.store = 1'b0;
    bus.clear = 1'b0;
    chk("clr_store.store_ack", 32'(bus.store_ack), 32'd0);
    chk("clr_store.busy", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("clr_store.busy_cycles", 32'(cyc), 32'd16);
    bus.rd_addr = 4'd2;
    tick();
    chk_read("clr_store.rd2", 8'h00, 1'b0);

    // Reset in the fifth busy cycle of a clear
    bus.store   = 1'b1;
    bus.wr_addr = 4'd14;
    bus.data    = 8'h33;
    tick();
    bus.store   = 1'b0;
    bus.rd_addr = 4'd14;
    bus.clear   = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort.busy_before", 32'(bus.busy), 32'd1);
    chk_read("abort.before", 8'h33, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.store_ack", 32'(bus.store_ack), 32'd0);
    chk_read("abort.reset", 8'h00, 1'b0);
    @(negedge clk);
    reset_n     = 1'b1;
    bus.store   = 1'b1;
    bus.wr_addr = 4'd9;
    bus.data    = 8'h77;
    bus.rd_addr = 4'd14;
    tick();
    chk("abort.store_ack_after", 32'(bus.store_ack), 32'd1);
    chk("abort.busy_after", 32'(bus.busy), 32'd0);
    chk_read("abort.rd14_masked", 8'h00, 1'b0);
    bus.store   = 1'b0;
    bus.rd_addr = 4'd9;
    tick();
    chk_read("abort.rd9", 8'h77, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/word_memory_bank.md
WORD_MEMORY_BANK -- requirements
Module: word_memory_bank

Interface
REQ-001 Parameter WIDTH, default 8: bits per stored word.
REQ-002 Parameter DEPTH, default 16: number of words; power of two, >= 2.
REQ-003 Derived constant ADDR_W = log2(DEPTH); not user-overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 store  input  1  write request; samples data into memory[wr_addr].
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 data  input  WIDTH  write data.
REQ-009 rd_addr  input  ADDR_W  read address, sampled every cycle.
REQ-010 memory  output  WIDTH  registered read data for the previous cycle's rd_addr.
REQ-011 n_mem  output  WIDTH  bitwise inverse of memory, combinational from memory.
REQ-012 rd_valid  output  1  registered; 1 when the word read has been written since the last reset or clear.
REQ-013 clear  input  1  one-cycle pulse starting a sequential clear of all words.
REQ-014 busy  output  1  1 while a clear is in progress.
REQ-015 store_ack  output  1  registered; 1 in the cycle after a store was accepted.

Function
REQ-016 Write: store=1 and busy=0 at an edge writes data to memory[wr_addr] and sets valid[wr_addr]; store_ack=1 next cycle.
REQ-017 store=1 while busy=1 is dropped: no write, no valid change, store_ack=0.
REQ-018 Read latency: exactly one cycle; memory and rd_valid reflect rd_addr sampled at the previous edge.
REQ-019 Read/write collision, same address same edge: read returns the old contents and old valid (read-before-write).
REQ-020 Unwritten word: memory = 0, rd_valid = 0, regardless of stored array contents.
REQ-021 FSM states: IDLE, CLEAR. IDLE->CLEAR on clear=1; CLEAR->IDLE after the word at index DEPTH-1 is cleared.
REQ-022 CLEAR: counter starts at 0, one word per cycle: word := 0, valid := 0; takes exactly DEPTH cycles; busy=1 in all of them.
REQ-023 Counter wraps from DEPTH-1 to 0 on exit; no out-of-range index is ever generated.
REQ-024 clear=1 while already in CLEAR is ignored; the clear in progress is not restarted.
REQ-025 clear and store in the same IDLE cycle: clear wins; store is dropped and store_ack=0.
REQ-026 Reads during CLEAR are serviced; a word already cleared returns 0/rd_valid=0, a word not yet cleared returns prior contents.
REQ-027 Word width is exact: no truncation, extension or partial-word writes.

Reset
REQ-028 reset_n=0 asynchronously forces: FSM IDLE, counter 0, all valid bits 0, memory 0, n_mem all ones, rd_valid 0, busy 0, store_ack 0.
REQ-029 Array contents are not reset; valid bits mask them per REQ-020.
REQ-030 Reset asserted mid-clear aborts the clear; after release the block is IDLE and accepts store on the first edge.

Structure
REQ-031 Shared package memory_pkg holds the FSM state enum (IDLE, CLEAR) and the default WIDTH/DEPTH constants.
REQ-032 One sub-module, mem_clear_ctrl, holds the FSM and clear counter and outputs busy, clr_en and clr_addr; the storage array and read path stay in the top.

Verification
REQ-033 Reset, then read addresses 0..15 -> memory=0x00, n_mem=0xFF, rd_valid=0 for every address.
REQ-034 store 0xA5 to addr 3, then read addr 3 -> store_ack=1 the cycle after the store; memory=0xA5, n_mem=0x5A and rd_valid=1 one cycle after rd_addr=3.
REQ-035 Same edge: store 0x3C to addr 7 (previously 0x11) with rd_addr=7 -> memory=0x11 the next cycle, then 0x3C the cycle after.
REQ-036 Fill all 16 words, pulse clear, assert store every cycle -> busy=1 for exactly 16 cycles, no store_ack during them; all reads then return 0/rd_valid=0.
REQ-037 reset_n low during cycle 5 of a clear -> busy=0 immediately; after release, store 0x77 to addr 9 is accepted and read back as 0x77.
REQ-038 clear and store asserted in the same IDLE cycle -> store dropped, store_ack=0, clear runs for the full 16 cycles.
